// File: rtl/vga_if.sv
// ============================================================================
// Module  : vga_if
// Brief   : Pixel-side bundle between renderer, VGA timing generator and pins
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_if #(
  parameter int CW = 10
);
  logic [11:0]   rbg;
  logic [1:0]    mode;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          in_active;
  logic [3:0]    red_out;
  logic [3:0]    blue_out;
  logic [3:0]    green_out;
  logic          hSync;
  logic          vSync;
  logic          frame_start;

  // Timing generator side: owns the raster, consumes colour and mode
  modport master (
    input  rbg, mode,
    output pixel_x, pixel_y, in_active,
    output red_out, blue_out, green_out, hSync, vSync, frame_start
  );

  // Renderer / pin side
  modport slave (
    output rbg, mode,
    input  pixel_x, pixel_y, in_active,
    input  red_out, blue_out, green_out, hSync, vSync, frame_start
  );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module  : vga_timing_gen
// Brief   : Parametrised VGA raster counters, sync generation and colour stage
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10
) (
  input  wire logic clk25,
  input  wire logic reset,
  vga_if.master     vga
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] c_H_LAST   = CW'(c_H_TOTAL - 1);
  localparam logic [CW-1:0] c_V_LAST   = CW'(c_V_TOTAL - 1);
  localparam logic [CW-1:0] c_H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] c_V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] c_HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] c_HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] c_VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] c_VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] c_BAR_LAST = CW'(H_ACTIVE / 8 - 1);
  localparam logic [CW-1:0] c_ZERO     = '0;
  localparam logic [CW-1:0] c_ONE      = CW'(1);

  localparam logic [1:0] c_MODE_PASS  = 2'd0;
  localparam logic [1:0] c_MODE_WHITE = 2'd1;
  localparam logic [1:0] c_MODE_BARS  = 2'd2;

  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic [CW-1:0] r_bar_cnt;
  logic [2:0]    r_bar;
  logic [1:0]    r_mode;
  logic [3:0]    r_red;
  logic [3:0]    r_blue;
  logic [3:0]    r_green;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_frame_start;

  logic          w_x_wrap;
  logic          w_origin;
  logic          w_in_active;
  logic          w_hs_on;
  logic          w_vs_on;
  logic [1:0]    w_mode;
  logic [11:0]   w_bar_rbg;
  logic [11:0]   w_rbg;

  assign w_x_wrap    = (r_x == c_H_LAST);
  assign w_origin    = (r_x == c_ZERO) && (r_y == c_ZERO);
  assign w_in_active = (r_x < c_H_ACT) && (r_y < c_V_ACT);
  assign w_hs_on     = (r_x >= c_HS_FIRST) && (r_x <= c_HS_LAST);
  assign w_vs_on     = (r_y >= c_VS_FIRST) && (r_y <= c_VS_LAST);
  // The pixel at (0,0) already uses the mode being latched on this edge
  assign w_mode      = w_origin ? vga.mode : r_mode;

  // Raster counters; the bar index is tracked incrementally to avoid a divider
  always_ff @(posedge clk25) begin
    if (reset) begin
      r_x       <= '0;
      r_y       <= '0;
      r_bar_cnt <= '0;
      r_bar     <= 3'd0;
    end else if (w_x_wrap) begin
      r_x       <= '0;
      r_bar_cnt <= '0;
      r_bar     <= 3'd0;
      r_y       <= (r_y == c_V_LAST) ? c_ZERO : r_y + c_ONE;
    end else begin
      r_x <= r_x + c_ONE;
      if (r_bar_cnt == c_BAR_LAST) begin
        r_bar_cnt <= '0;
        r_bar     <= r_bar + 3'd1;
      end else begin
        r_bar_cnt <= r_bar_cnt + c_ONE;
      end
    end
  end

  // Colour order within a word is {red, blue, green}
  always_comb begin
    w_bar_rbg = 12'h000;
    case (r_bar)
      3'd0:    w_bar_rbg = 12'hFFF;
      3'd1:    w_bar_rbg = 12'hF0F;
      3'd2:    w_bar_rbg = 12'h0FF;
      3'd3:    w_bar_rbg = 12'h00F;
      3'd4:    w_bar_rbg = 12'hFF0;
      3'd5:    w_bar_rbg = 12'hF00;
      3'd6:    w_bar_rbg = 12'h0F0;
      default: w_bar_rbg = 12'h000;
    endcase
  end

  always_comb begin
    w_rbg = 12'h000;
    if (w_in_active) begin
      case (w_mode)
        c_MODE_PASS:  w_rbg = vga.rbg;
        c_MODE_WHITE: w_rbg = 12'hFFF;
        c_MODE_BARS:  w_rbg = w_bar_rbg;
        default:      w_rbg = 12'h000;
      endcase
    end
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      r_mode        <= 2'd0;
      r_red         <= 4'h0;
      r_blue        <= 4'h0;
      r_green       <= 4'h0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_frame_start <= 1'b0;
    end else begin
      if (w_origin) begin
        r_mode <= vga.mode;
      end
      r_red         <= w_rbg[11:8];
      r_blue        <= w_rbg[7:4];
      r_green       <= w_rbg[3:0];
      r_hsync       <= w_hs_on ? HS_POL : ~HS_POL;
      r_vsync       <= w_vs_on ? VS_POL : ~VS_POL;
      r_frame_start <= w_origin;
    end
  end

  assign vga.pixel_x     = r_x;
  assign vga.pixel_y     = r_y;
  assign vga.in_active   = w_in_active;
  assign vga.red_out     = r_red;
  assign vga.blue_out    = r_blue;
  assign vga.green_out   = r_green;
  assign vga.hSync       = r_hsync;
  assign vga.vSync       = r_vsync;
  assign vga.frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module  : tb_vga_timing_gen
// Brief   : Directed bench: default timing, short-frame and tiny-raster variants
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

  logic clk25 = 1'b0;
  logic reset;

  vga_if #(.CW(10)) ifd ();
  vga_if #(.CW(10)) ifm ();
  vga_if #(.CW(10)) ifs ();

  // Full default timing
  vga_timing_gen dut_d (.clk25(clk25), .reset(reset), .vga(ifd));

  // Default horizontal timing, 12-line frame so several frames fit in the run
  vga_timing_gen #(
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_m (.clk25(clk25), .reset(reset), .vga(ifm));

  // 12-cycle line, 7-line frame, active-high hSync
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1)
  ) dut_s (.clk25(clk25), .reset(reset), .vga(ifs));

  always #20 clk25 = ~clk25;

  int checks   = 0;
  int failures = 0;

  int bad_d_col, bad_d_sync, bad_d_fs, bad_d_xy, hs_low_d, hs_first_d;
  int bad_m_col, bad_m_sync, bad_m_fs, vs_low_m, vs_low_m_f0, fs_m;
  int bad_s_col, bad_s_sync, bad_s_fs, bad_s_xy, fs_s;
  int x, y, f, em, xs, ys;
  logic [11:0] exp_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  function automatic logic [11:0] bar_rbg(input int k);
    case (k)
      0: return 12'hFFF;  // white
      1: return 12'hF0F;  // yellow
      2: return 12'h0FF;  // cyan
      3: return 12'h00F;  // green
      4: return 12'hFF0;  // magenta
      5: return 12'hF00;  // red
      6: return 12'h0F0;  // blue
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] rgb_of(input logic [3:0] r, input logic [3:0] b,
                                         input logic [3:0] g);
    return {r, b, g};
  endfunction

  initial begin
    {bad_d_col, bad_d_sync, bad_d_fs, bad_d_xy, hs_low_d, hs_first_d} = '0;
    {bad_m_col, bad_m_sync, bad_m_fs, vs_low_m, vs_low_m_f0, fs_m} = '0;
    {bad_s_col, bad_s_sync, bad_s_fs, bad_s_xy, fs_s} = '0;
    hs_first_d = -1;
    reset = 1'b1;
    ifd.mode = 2'd0; ifd.rbg = 12'hABC;
    ifm.mode = 2'd2; ifm.rbg = 12'h000;
    ifs.mode = 2'd1; ifs.rbg = 12'h000;

    // Power-on reset
    repeat (3) tick();
    chk("rst_x",     32'(ifd.pixel_x), 32'd0);
    chk("rst_y",     32'(ifd.pixel_y), 32'd0);
    chk("rst_col",   32'(rgb_of(ifd.red_out, ifd.blue_out, ifd.green_out)), 32'h000);
    chk("rst_hs",    32'(ifd.hSync), 32'd1);
    chk("rst_vs",    32'(ifd.vSync), 32'd1);
    chk("rst_fs",    32'(ifd.frame_start), 32'd0);
    chk("rst_s_hs",  32'(ifs.hSync), 32'd0);
    reset = 1'b0;

    // Sample after edge c shows the pixel the counters held at edge c
    for (int c = 0; c < 28800; c++) begin
      if (c == 2400) ifm.mode = 2'd1;
      if (c == 12000) begin
        ifm.mode = 2'd0;
        ifm.rbg  = 12'h5A3;
      end
      tick();

      // ---- default timing ----
      x = c % 800; y = c / 800;
      exp_c = (x < 640) ? 12'hABC : 12'h000;
      if (rgb_of(ifd.red_out, ifd.blue_out, ifd.green_out) !== exp_c) bad_d_col++;
      if (ifd.hSync !== 1'((x < 656) || (x > 751))) bad_d_sync++;
      if (ifd.vSync !== 1'b1) bad_d_sync++;
      if (ifd.frame_start !== 1'(c == 0)) bad_d_fs++;
      if (ifd.pixel_x !== 10'((c + 1) % 800) || ifd.pixel_y !== 10'((c + 1) / 800)) bad_d_xy++;
      if (ifd.in_active !== 1'(((c + 1) % 800) < 640)) bad_d_xy++;
      if (c < 800 && ifd.hSync === 1'b0) begin
        if (hs_first_d < 0) hs_first_d = c;
        hs_low_d++;
      end
      if (c == 0)   chk("d_col_x0",   32'(rgb_of(ifd.red_out, ifd.blue_out, ifd.green_out)), 32'hABC);
      if (c == 0)   chk("d_fs_first", 32'(ifd.frame_start), 32'd1);
      if (c == 639) chk("d_col_x639", 32'(rgb_of(ifd.red_out, ifd.blue_out, ifd.green_out)), 32'hABC);
      if (c == 640) chk("d_col_x640", 32'(rgb_of(ifd.red_out, ifd.blue_out, ifd.green_out)), 32'h000);
      if (c == 799) chk("d_wrap_x",   32'(ifd.pixel_x), 32'd0);
      if (c == 799) chk("d_wrap_y",   32'(ifd.pixel_y), 32'd1);

      // ---- 12-line frame, mode 2 -> 1 -> 0 across frames ----
      f = c / 9600; ym_calc: begin end
      y = (c / 800) % 12;
      em = (f == 0) ? 2 : ((f == 1) ? 1 : 0);
      if (x < 640 && y < 6)
        exp_c = (em == 2) ? bar_rbg(x / 80) : ((em == 1) ? 12'hFFF : 12'h5A3);
      else
        exp_c = 12'h000;
      if (rgb_of(ifm.red_out, ifm.blue_out, ifm.green_out) !== exp_c) bad_m_col++;
      if (ifm.hSync !== 1'((x < 656) || (x > 751))) bad_m_sync++;
      if (ifm.vSync !== 1'((y != 8) && (y != 9))) bad_m_sync++;
      if (ifm.frame_start !== 1'((c % 9600) == 0)) bad_m_fs++;
      if (ifm.vSync === 1'b0) begin
        vs_low_m++;
        if (c < 9600) vs_low_m_f0++;
      end
      if (ifm.frame_start === 1'b1) fs_m++;
      if (c == 79)    chk("m_bar0_x79",  32'(rgb_of(ifm.red_out, ifm.blue_out, ifm.green_out)), 32'hFFF);
      if (c == 80)    chk("m_bar1_x80",  32'(rgb_of(ifm.red_out, ifm.blue_out, ifm.green_out)), 32'hF0F);
      if (c == 560)   chk("m_bar7_x560", 32'(rgb_of(ifm.red_out, ifm.blue_out, ifm.green_out)), 32'h000);
      if (c == 640)   chk("m_blank_x640", 32'(rgb_of(ifm.red_out, ifm.blue_out, ifm.green_out)), 32'h000);
      if (c == 3280)  chk("m_latch_hold", 32'(rgb_of(ifm.red_out, ifm.blue_out, ifm.green_out)), 32'hF0F);
      if (c == 9600)  chk("m_white_f1",  32'(rgb_of(ifm.red_out, ifm.blue_out, ifm.green_out)), 32'hFFF);
      if (c == 13610) chk("m_white_hold", 32'(rgb_of(ifm.red_out, ifm.blue_out, ifm.green_out)), 32'hFFF);
      if (c == 19200) chk("m_pass_f2",   32'(rgb_of(ifm.red_out, ifm.blue_out, ifm.green_out)), 32'h5A3);
      if (c == 24000) chk("m_blank_y6",  32'(rgb_of(ifm.red_out, ifm.blue_out, ifm.green_out)), 32'h000);

      // ---- tiny raster ----
      xs = c % 12; ys = (c / 12) % 7;
      exp_c = (xs < 8 && ys < 4) ? 12'hFFF : 12'h000;
      if (rgb_of(ifs.red_out, ifs.blue_out, ifs.green_out) !== exp_c) bad_s_col++;
      if (ifs.hSync !== 1'((xs == 9) || (xs == 10))) bad_s_sync++;
      if (ifs.vSync !== 1'(ys != 5)) bad_s_sync++;
      if (ifs.frame_start !== 1'((c % 84) == 0)) bad_s_fs++;
      if (ifs.pixel_x !== 10'((c + 1) % 12) || ifs.pixel_y !== 10'(((c + 1) / 12) % 7)) bad_s_xy++;
      if (ifs.frame_start === 1'b1) fs_s++;
      if (c == 9)  chk("s_hs_x9",  32'(ifs.hSync), 32'd1);
      if (c == 11) chk("s_hs_x11", 32'(ifs.hSync), 32'd0);
      if (c == 84) chk("s_fs_84",  32'(ifs.frame_start), 32'd1);
    end

    chk("d_colour_bad", 32'(bad_d_col), 32'd0);
    chk("d_sync_bad",   32'(bad_d_sync), 32'd0);
    chk("d_fs_bad",     32'(bad_d_fs), 32'd0);
    chk("d_xy_bad",     32'(bad_d_xy), 32'd0);
    chk("d_hs_low_cnt", 32'(hs_low_d), 32'd96);
    chk("d_hs_first",   32'(hs_first_d), 32'd656);
    chk("m_colour_bad", 32'(bad_m_col), 32'd0);
    chk("m_sync_bad",   32'(bad_m_sync), 32'd0);
    chk("m_fs_bad",     32'(bad_m_fs), 32'd0);
    chk("m_vs_low_f0",  32'(vs_low_m_f0), 32'd1600);
    chk("m_vs_low_all", 32'(vs_low_m), 32'd4800);
    chk("m_fs_count",   32'(fs_m), 32'd3);
    chk("s_colour_bad", 32'(bad_s_col), 32'd0);
    chk("s_sync_bad",   32'(bad_s_sync), 32'd0);
    chk("s_fs_bad",     32'(bad_s_fs), 32'd0);
    chk("s_xy_bad",     32'(bad_s_xy), 32'd0);
    chk("s_fs_count",   32'(fs_s), 32'd343);

    // Mid-frame reset while the default raster is inside the active area
    repeat (300) tick();
    chk("mid_pre_x", 32'(ifd.pixel_x), 32'd300);
    reset = 1'b1;
    repeat (3) tick();
    chk("mid_rst_x",   32'(ifd.pixel_x), 32'd0);
    chk("mid_rst_y",   32'(ifd.pixel_y), 32'd0);
    chk("mid_rst_col", 32'(rgb_of(ifd.red_out, ifd.blue_out, ifd.green_out)), 32'h000);
    chk("mid_rst_hs",  32'(ifd.hSync), 32'd1);
    chk("mid_rst_vs",  32'(ifd.vSync), 32'd1);
    chk("mid_rst_fs",  32'(ifd.frame_start), 32'd0);
    chk("mid_rst_m_y", 32'(ifm.pixel_y), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_fs",  32'(ifd.frame_start), 32'd1);
    chk("post_rst_x",   32'(ifd.pixel_x), 32'd1);
    chk("post_rst_col", 32'(rgb_of(ifd.red_out, ifd.blue_out, ifd.green_out)), 32'hABC);
    tick();
    chk("post_rst_fs1", 32'(ifd.frame_start), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
